hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline stall/flush sequencer for the 5-stage MIPS core. It sits beside the forwarding unit and drives the write-enables of the PC and IF/ID, and the bubble/flush controls of IF/ID and ID/EX. It handles load-use hazards, branch operand hazards (one or two stall cycles), taken-branch/jump flushes, and whole-pipeline freeze while a multi-cycle data-memory access completes, with a timeout watchdog.

## Interface
- TIMEOUT_CYCLES, 255: MEM_WAIT cycles without ack before HALT; range 1..2^WAIT_W-1.
- WAIT_W, 8: width of the wait counter.
- PERF_W, 32: width of the performance counters (only with HAZARD_PERF_CNT_EN).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- IF_ID_Rs_i  in  5  Rs of the instruction in ID.
- IF_ID_Rt_i  in  5  Rt of the instruction in ID.
- ID_branch_i  in  1  ID holds a beq.
- ID_branch_taken_i  in  1  ID comparator result; meaningful only when no stall is raised.
- ID_jump_i  in  1  ID holds a j.
- ID_EX_MemRead_i  in  1  EX holds a load.
- ID_EX_RegWrite_i  in  1  EX instruction writes a register.
- ID_EX_Rd_i  in  5  EX destination register (post dst-mux).
- EX_MEM_MemReq_i  in  1  MEM stage issuing a data-memory read/write this cycle.
- mem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC update enable.
- IF_ID_write_o  out  1  IF/ID update enable.
- IF_ID_flush_o  out  1  load NOP into IF/ID.
- ID_EX_bubble_o  out  1  zero ID/EX control fields.
- pipe_freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB.
- mem_timeout_o  out  1  sticky watchdog flag.
- state_o  out  2  FSM state: RUN=00, MEM_WAIT=01, STALL2=10, HALT=11.
- stall_cnt_o  out  PERF_W  (macro only) stall cycles.
- flush_cnt_o  out  PERF_W  (macro only) flush cycles.

## Operation
- Hazard terms:
  - m = rs or rt match with ID_EX_Rd_i, where ID_EX_Rd_i != 0.
  - load_use = ID_EX_MemRead_i & m.
  - br_dep = ID_branch_i & ID_EX_RegWrite_i & !ID_EX_MemRead_i & m.
  - mem_hold = EX_MEM_MemReq_i & !mem_ack_i.
- "Normal" output set: pc_write=1, IF_ID_write=1, flush=bubble=freeze=0.
- Stall set: pc_write=0, IF_ID_write=0, bubble=1.
- Freeze set: pc_write=0, IF_ID_write=0, freeze=1, bubble=0, flush=0.
- Outputs are combinational (Mealy) from state plus inputs; they act in the same cycle.
- RUN, priority order:
  - mem_hold: freeze set; ret<=RUN; next MEM_WAIT; wait_cnt<=1.
  - load_use or br_dep: stall set. If load_use & ID_branch_i, next STALL2; else stay RUN.
  - (ID_branch_i & ID_branch_taken_i) | ID_jump_i: normal set plus IF_ID_flush=1.
  - Otherwise: normal set.
- STALL2:
  - mem_hold: freeze set; ret<=STALL2; next MEM_WAIT; wait_cnt<=1.
  - Else: stall set, next RUN. Taken/jump is ignored this cycle.
- MEM_WAIT:
  - No ack: freeze set; wait_cnt+1. If wait_cnt==TIMEOUT_CYCLES, next HALT.
  - Ack: freeze off. Outputs and next state are exactly those of state ret, evaluated with mem_hold=0. wait_cnt<=0.
  - Ack in the timeout cycle: ack wins.
- HALT: freeze set; mem_timeout_o=1; all inputs ignored until reset.
- A flush is never asserted in a cycle with stall or freeze.

## Timing
- Stall/flush/freeze latency: 0 cycles (combinational). State changes take 1 cycle.
- load_use not on a branch: 1 stall cycle. br_dep: 1 cycle. Load feeding a branch: 2 cycles (RUN then STALL2).
- Memory wait of N cycles (ack on cycle N of the request): N-1 freeze cycles; the pipeline advances on the ack cycle.
- Reset (async, any state, including mid-MEM_WAIT):
  - state/ret=RUN, wait_cnt=0, mem_timeout_o=0, counters=0.
  - While rst_i is high, outputs are forced to the normal set and state_o=00.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt_o increments every non-reset cycle with pc_write_o=0 and state!=HALT.
  - flush_cnt_o increments every cycle with IF_ID_flush_o=1.
  - Both counters saturate at all-ones.
- Undefined: both ports and their flops are absent; all other behaviour is identical.

## Test plan
- lw $2 in EX (Rd=2), ID add reads $2 -> 1 cycle: pc_write=0, bubble=1, state stays 00; next cycle normal.
- lw $3 in EX, ID beq on $3 -> stall in RUN, state 10, stall again, back to 00. Taken in third cycle -> IF_ID_flush=1 exactly once.
- ID_EX_Rd=0 with MemRead=1, ID uses $0 -> no stall.
- MemReq with ack 3 cycles later in STALL2 -> freeze 2 cycles in 01, then the ack cycle performs the STALL2 stall, then RUN.
- MemReq, no ack, TIMEOUT_CYCLES=4 -> state 01 for 4 cycles, then 11 with mem_timeout_o=1 and freeze held. rst_i pulse -> 00, flag cleared.
- With HAZARD_PERF_CNT_EN: 1 load-use plus 1 jump -> stall_cnt_o=1, flush_cnt_o=1. Force 2^PERF_W-1 -> holds.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX hazard inputs, memory handshake and the
// pipeline enable/bubble/flush/freeze controls driven back to the datapath.
// The datapath side uses the master modport, the sequencer the slave modport.
interface hazard_ctrl_if;
  logic [4:0] IF_ID_Rs_i;
  logic [4:0] IF_ID_Rt_i;
  logic       ID_branch_i;
  logic       ID_branch_taken_i;
  logic       ID_jump_i;
  logic       ID_EX_MemRead_i;
  logic       ID_EX_RegWrite_i;
  logic [4:0] ID_EX_Rd_i;
  logic       EX_MEM_MemReq_i;
  logic       mem_ack_i;
  logic       pc_write_o;
  logic       IF_ID_write_o;
  logic       IF_ID_flush_o;
  logic       ID_EX_bubble_o;
  logic       pipe_freeze_o;
  logic       mem_timeout_o;
  logic [1:0] state_o;

  modport master (
    output IF_ID_Rs_i, IF_ID_Rt_i, ID_branch_i, ID_branch_taken_i, ID_jump_i,
           ID_EX_MemRead_i, ID_EX_RegWrite_i, ID_EX_Rd_i, EX_MEM_MemReq_i, mem_ack_i,
    input  pc_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
           pipe_freeze_o, mem_timeout_o, state_o
  );

  modport slave (
    input  IF_ID_Rs_i, IF_ID_Rt_i, ID_branch_i, ID_branch_taken_i, ID_jump_i,
           ID_EX_MemRead_i, ID_EX_RegWrite_i, ID_EX_Rd_i, EX_MEM_MemReq_i, mem_ack_i,
    output pc_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
           pipe_freeze_o, mem_timeout_o, state_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage MIPS pipeline.
// Handles load-use and branch-operand stalls, taken-branch/jump flushes,
// and freezes the whole pipeline while a data-memory access is pending,
// halting if the access never completes.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int WAIT_W         = 8,
  parameter int PERF_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  hazard_ctrl_if.slave      hif
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    STALL2   = 2'b10,
    HALT     = 2'b11
  } state_t;

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  state_t            eval_st;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;

  logic match, load_use, br_dep, mem_hold, hold;
  logic pc_write, if_id_write, flush, bubble, freeze;

  // Hazard terms; register $0 never creates a dependency.
  assign match    = (hif.ID_EX_Rd_i != 5'd0) &&
                    ((hif.IF_ID_Rs_i == hif.ID_EX_Rd_i) || (hif.IF_ID_Rt_i == hif.ID_EX_Rd_i));
  assign load_use = hif.ID_EX_MemRead_i & match;
  assign br_dep   = hif.ID_branch_i & hif.ID_EX_RegWrite_i & ~hif.ID_EX_MemRead_i & match;
  assign mem_hold = hif.EX_MEM_MemReq_i & ~hif.mem_ack_i;

  // State register, return state, wait counter and sticky timeout flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      ret_q     <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state and Mealy controls. An ack in MEM_WAIT re-evaluates the
  // saved return state as if no memory hold were present, so the pipeline
  // advances in the ack cycle itself.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    wait_d      = wait_q;
    timeout_d   = timeout_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    flush       = 1'b0;
    bubble      = 1'b0;
    freeze      = 1'b0;
    eval_st     = state_q;
    hold        = mem_hold;

    if (state_q == MEM_WAIT && hif.mem_ack_i) begin
      eval_st = ret_q;
      hold    = 1'b0;
      wait_d  = '0;
    end

    case (eval_st)
      RUN: begin
        state_d = RUN;
        if (hold) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          freeze      = 1'b1;
          ret_d       = RUN;
          state_d     = MEM_WAIT;
          wait_d      = WAIT_W'(1);
        end else if (load_use || br_dep) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          bubble      = 1'b1;
          if (load_use && hif.ID_branch_i) state_d = STALL2;
        end else if ((hif.ID_branch_i && hif.ID_branch_taken_i) || hif.ID_jump_i) begin
          flush = 1'b1;
        end
      end
      STALL2: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if (hold) begin
          freeze  = 1'b1;
          ret_d   = STALL2;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          bubble  = 1'b1;
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        freeze      = 1'b1;
        wait_d      = wait_q + 1'b1;
        if (wait_q == WAIT_W'(TIMEOUT_CYCLES)) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end
      end
      default: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        freeze      = 1'b1;
      end
    endcase
  end

  // While reset is held the datapath sees the free-running control set.
  assign hif.pc_write_o     = rst_i | pc_write;
  assign hif.IF_ID_write_o  = rst_i | if_id_write;
  assign hif.IF_ID_flush_o  = ~rst_i & flush;
  assign hif.ID_EX_bubble_o = ~rst_i & bubble;
  assign hif.pipe_freeze_o  = ~rst_i & freeze;
  assign hif.mem_timeout_o  = ~rst_i & timeout_q;
  assign hif.state_o        = rst_i ? 2'b00 : state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters of stalled (non-HALT) cycles and flush cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hif.pc_write_o && state_q != HALT && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    if (hif.IF_ID_flush_o && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
